// File: rtl/data_mem_master_if.sv
// data_mem_master_if: core request port and DataMemory port of data_mem_master.
//   master (the controller): in  req, we, size, signed_ld, addr, wdata, mem_readdata
//                            out ready, done, rdata, err, mem_memwrite, mem_endereco, mem_writedata
//   slave  (core + memory) : the same signals with the opposite directions
interface data_mem_master_if #(parameter int ADDR_W = 32);
  logic req, we, signed_ld, ready, done, err, mem_memwrite;
  logic [1:0] size;
  logic [ADDR_W-1:0] addr, mem_endereco;
  logic [31:0] wdata, rdata, mem_writedata, mem_readdata;
  modport master(
    input req, we, size, signed_ld, addr, wdata, mem_readdata,
    output ready, done, rdata, err, mem_memwrite, mem_endereco, mem_writedata
  );
  modport slave(
    output req, we, size, signed_ld, addr, wdata, mem_readdata,
    input ready, done, rdata, err, mem_memwrite, mem_endereco, mem_writedata
  );
endinterface

// File: rtl/data_mem_master.sv
// data_mem_master: turns byte/half/word load-store requests into word-aligned DataMemory cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : core handshake (req/we/size/signed_ld/addr/wdata -> ready/done/rdata/err)
//                and DataMemory port (mem_memwrite/mem_endereco/mem_writedata <- mem_readdata)
module data_mem_master #(parameter int ADDR_W = 32) (
  input logic clk,
  input logic rst_n,
  data_mem_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t state, nxt;
  logic we_q, sgn_q, err_q, acc, bad;
  logic [1:0] size_q, off_q;
  logic [4:0] sh;
  logic [31:0] wdata_q, mask, merged, lane, ld;
  assign acc = (state == IDLE) && bus.req;
  assign bad = (bus.size == 2'b11) | ((bus.size == 2'b01) & bus.addr[0]) |
               ((bus.size == 2'b10) & (|bus.addr[1:0]));
  assign bus.ready = state == IDLE;
  assign bus.done = state == RESP;
  assign bus.err = bus.done & err_q;
  // Combinational so an asynchronous reset drops the strobe immediately.
  assign bus.mem_memwrite = state == WR;
  // Lane offset in bits; halfword accesses are aligned so off_q is 0 or 2.
  assign sh = {off_q, 3'b000};
  assign mask = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
  assign merged = (bus.mem_readdata & ~mask) | ((wdata_q << sh) & mask);
  assign lane = bus.mem_readdata >> sh;
  assign ld = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
              size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : bus.mem_readdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (!bus.req ? IDLE : bad ? RESP :
                           (bus.we && bus.size == 2'b10) ? WR : RD) :
          state == RD   ? (we_q ? WR : RESP) :
          state == WR   ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b00;
      off_q <= 2'b00;
      wdata_q <= '0;
      bus.rdata <= '0;
      bus.mem_endereco <= '0;
      bus.mem_writedata <= '0;
    end else begin
      if (acc) begin
        we_q <= bus.we;
        sgn_q <= bus.signed_ld;
        err_q <= bad;
        size_q <= bus.size;
        off_q <= bus.addr[1:0];
        wdata_q <= bus.wdata;
        bus.mem_endereco <= {bus.addr[ADDR_W-1:2], 2'b00};
        if (!bad && bus.we && bus.size == 2'b10) bus.mem_writedata <= bus.wdata;
      end
      // The read word is consumed on the closing edge of RD: merged for sub-word stores, extended for loads.
      if (state == RD && we_q) bus.mem_writedata <= merged;
      if (state == RD && !we_q) bus.rdata <= ld;
    end
  end
endmodule

// File: tb/tb_data_mem_master.sv
// tb_data_mem_master: randomized and directed checks of data_mem_master against a byte-level memory model.
module tb_data_mem_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  logic [31:0] mem [16] = '{default: 32'h0};
  logic [7:0] rb [64];
  logic [31:0] exp_rd = 32'h0;
  int lat, nw;
  logic e, hs;
  logic [31:0] rd, wa, wd;

  always #5 clk = ~clk;

  data_mem_master_if #(.ADDR_W(32)) bus();
  data_mem_master #(.ADDR_W(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.master));

  assign bus.mem_readdata = mem[bus.mem_endereco[5:2]];
  always @(posedge clk) if (bus.mem_memwrite) mem[bus.mem_endereco[5:2]] <= bus.mem_writedata;

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic is_bad(input logic [1:0] s, input logic [31:0] a);
    return s == 2'b11 || (s == 2'b01 && a % 2 != 0) || (s == 2'b10 && a % 4 != 0);
  endfunction

  function automatic int exp_lat(input logic w, input logic [1:0] s, input logic [31:0] a);
    if (is_bad(s, a)) return 1;
    if (!w || s == 2'b10) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic sg, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int n = nbytes(s);
    for (int i = 0; i < n; i++) v = v | (32'(rb[a[5:0] + i]) << (8 * i));
    if (n < 4 && sg && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++) rb[a[5:0] + i] = d[8 * i +: 8];
  endtask

  function automatic logic mem_ok();
    for (int i = 0; i < 16; i++)
      if (mem[i] !== {rb[4 * i + 3], rb[4 * i + 2], rb[4 * i + 1], rb[4 * i]}) return 1'b0;
    return 1'b1;
  endfunction

  // Drives one request and observes it: latency to done (0 = timed out), err, rdata at done,
  // number of write-strobe cycles with the last address/data seen, and whether the handshake
  // kept ready high at accept and low until done.
  task automatic run(input logic w, input logic [1:0] s, input logic sg, input logic [31:0] a,
                     input logic [31:0] d, input logic hold, output int l, output logic er,
                     output logic [31:0] r, output int n, output logic [31:0] xa,
                     output logic [31:0] xd, output logic ok);
    @(negedge clk);
    ok = bus.ready;
    bus.req = 1'b1; bus.we = w; bus.size = s; bus.signed_ld = sg; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1 if (!hold) bus.req = 1'b0;
    l = 0; n = 0; er = 1'b0; r = 32'h0; xa = 32'h0; xd = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.ready) ok = 1'b0;
      if (bus.mem_memwrite) begin n++; xa = bus.mem_endereco; xd = bus.mem_writedata; end
      if (bus.done) begin l = i; er = bus.err; r = bus.rdata; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.ready, bus.done, bus.err, bus.mem_memwrite, bus.rdata, bus.mem_endereco, bus.mem_writedata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      errs++; $display("FAIL reset outputs: rdy=%b done=%b err=%b mw=%b rd=%h ad=%h wd=%h, want 1 0 0 0 0 0 0",
        bus.ready, bus.done, bus.err, bus.mem_memwrite, bus.rdata, bus.mem_endereco, bus.mem_writedata);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    run(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 1'b0, lat, e, rd, nw, wa, wd, hs);
    model_store(2'b10, 32'h4, 32'hDEADBEEF);
    checks++;
    if ({lat, nw, wa, wd, e, hs} !== {32'd2, 32'd1, 32'h4, 32'hDEADBEEF, 1'b0, 1'b1}) begin
      errs++; $display("FAIL word_store: lat=%0d writes=%0d addr=%h data=%h err=%b hs=%b, want 2 1 4 deadbeef 0 1",
        lat, nw, wa, wd, e, hs);
    end
    run(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, lat, e, rd, nw, wa, wd, hs);
    exp_rd = 32'hDEADBEEF;
    checks++;
    if ({lat, nw, rd, e} !== {32'd2, 32'd0, 32'hDEADBEEF, 1'b0}) begin
      errs++; $display("FAIL word_load: lat=%0d writes=%0d rdata=%h err=%b, want 2 0 deadbeef 0", lat, nw, rd, e);
    end
  endtask

  task automatic test_byte_rmw();
    run(1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEBABE, 1'b0, lat, e, rd, nw, wa, wd, hs);
    model_store(2'b10, 32'h8, 32'hCAFEBABE);
    run(1'b1, 2'b00, 1'b0, 32'hA, 32'h11, 1'b0, lat, e, rd, nw, wa, wd, hs);
    model_store(2'b00, 32'hA, 32'h11);
    checks++;
    if ({lat, nw, wa, wd, e} !== {32'd3, 32'd1, 32'h8, 32'hCA11BABE, 1'b0}) begin
      errs++; $display("FAIL byte_rmw: lat=%0d writes=%0d addr=%h data=%h err=%b, want 3 1 8 ca11babe 0",
        lat, nw, wa, wd, e);
    end
    checks++;
    if (mem[2] !== 32'hCA11BABE) begin
      errs++; $display("FAIL byte_rmw_mem: word8=%h want ca11babe", mem[2]);
    end
    run(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 1'b0, lat, e, rd, nw, wa, wd, hs);
    checks++;
    if ({lat, rd} !== {32'd2, 32'hFFFFFFCA}) begin
      errs++; $display("FAIL byte_load_signed: lat=%0d rdata=%h want 2 ffffffca", lat, rd);
    end
    run(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 1'b0, lat, e, rd, nw, wa, wd, hs);
    exp_rd = 32'h000000CA;
    checks++;
    if ({lat, rd} !== {32'd2, 32'h000000CA}) begin
      errs++; $display("FAIL byte_load_unsigned: lat=%0d rdata=%h want 2 000000ca", lat, rd);
    end
  endtask

  task automatic test_halfword();
    run(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 1'b0, lat, e, rd, nw, wa, wd, hs);
    checks++;
    if ({lat, rd, e} !== {32'd2, 32'hFFFFBABE, 1'b0}) begin
      errs++; $display("FAIL half_load_signed: lat=%0d rdata=%h err=%b want 2 ffffbabe 0", lat, rd, e);
    end
    run(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 1'b0, lat, e, rd, nw, wa, wd, hs);
    exp_rd = 32'h0000BABE;
    checks++;
    if ({lat, rd} !== {32'd2, 32'h0000BABE}) begin
      errs++; $display("FAIL half_load_unsigned: lat=%0d rdata=%h want 2 0000babe", lat, rd);
    end
    run(1'b1, 2'b01, 1'b0, 32'hA, 32'h1234, 1'b0, lat, e, rd, nw, wa, wd, hs);
    model_store(2'b01, 32'hA, 32'h1234);
    checks++;
    if ({lat, nw, wd, mem[2]} !== {32'd3, 32'd1, 32'h1234BABE, 32'h1234BABE}) begin
      errs++; $display("FAIL half_store: lat=%0d writes=%0d data=%h word8=%h want 3 1 1234babe 1234babe",
        lat, nw, wd, mem[2]);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0] sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'h6, 32'h3, 32'h4};
    logic wr [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run(wr[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, 1'b0, lat, e, rd, nw, wa, wd, hs);
      checks++;
      if ({lat, e, nw, rd} !== {32'd1, 1'b1, 32'd0, exp_rd}) begin
        errs++; $display("FAIL misaligned[%0d]: lat=%0d err=%b writes=%0d rdata=%h want 1 1 0 %h",
          i, lat, e, nw, rd, exp_rd);
      end
    end
    checks++;
    if (!mem_ok()) begin
      errs++; $display("FAIL misaligned_mem: memory contents %b want 1", mem_ok());
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] s = 2'($urandom_range(0, 2));
      logic sg = 1'($urandom);
      logic [31:0] a = $urandom_range(0, 63) & (s == 2'b10 ? 32'h3C : s == 2'b01 ? 32'h3E : 32'h3F);
      exp_rd = model_load(s, sg, a);
      run(1'b0, s, sg, a, 32'h0, 1'b1, lat, e, rd, nw, wa, wd, hs);
      if (lat != 0) dones++;
      checks++;
      if ({lat, hs, e, rd} !== {32'd2, 1'b1, 1'b0, exp_rd}) begin
        errs++; $display("FAIL back_to_back[%0d]: lat=%0d hs=%b err=%b rdata=%h want 2 1 0 %h",
          i, lat, hs, e, rd, exp_rd);
      end
    end
    bus.req = 1'b0;
    @(negedge clk);
    checks++;
    if ({dones, bus.done, bus.ready} !== {32'd6, 1'b0, 1'b1}) begin
      errs++; $display("FAIL back_to_back_end: dones=%0d done=%b ready=%b want 6 0 1", dones, bus.done, bus.ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic w = 1'($urandom);
      logic [1:0] s = 2'($urandom);
      logic sg = 1'($urandom);
      logic [31:0] a = $urandom_range(0, 63);
      logic [31:0] d = $urandom;
      logic b = is_bad(s, a);
      int el = exp_lat(w, s, a);
      if (!w && !b) exp_rd = model_load(s, sg, a);
      run(w, s, sg, a, d, 1'b0, lat, e, rd, nw, wa, wd, hs);
      if (w && !b) model_store(s, a, d);
      checks++;
      if ({lat, e, rd, nw, hs, mem_ok()} !== {el, b, exp_rd, (w && !b) ? 32'd1 : 32'd0, 1'b1, 1'b1}) begin
        errs++; $display("FAIL random[%0d] we=%b size=%b addr=%h: lat=%0d err=%b rdata=%h writes=%0d hs=%b mem=%b want %0d %b %h %0d 1 1",
          i, w, s, a, lat, e, rd, nw, hs, mem_ok(), el, b, exp_rd, (w && !b) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.signed_ld = 1'b0; bus.addr = 32'hD; bus.wdata = 32'hAA;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_memwrite !== 1'b1) begin
      errs++; $display("FAIL reset_mid_in_wr: mem_memwrite=%b want 1", bus.mem_memwrite);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.done, bus.err, bus.mem_memwrite, bus.rdata, bus.mem_endereco, bus.mem_writedata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      errs++; $display("FAIL reset_mid_outputs: rdy=%b done=%b err=%b mw=%b rd=%h ad=%h wd=%h, want 1 0 0 0 0 0 0",
        bus.ready, bus.done, bus.err, bus.mem_memwrite, bus.rdata, bus.mem_endereco, bus.mem_writedata);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++;
    if ({bus.ready, dones, mem_ok()} !== {1'b1, 32'd0, 1'b1}) begin
      errs++; $display("FAIL reset_mid_after: ready=%b dones=%0d mem=%b want 1 0 1", bus.ready, dones, mem_ok());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rb[i] = 8'h0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.signed_ld = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_halfword();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
